// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: key debounce, start/stop/lap/clear sequencer and 10 ms count tick for the BCD stopwatch.
// Optional lap/display-hold feature is enabled by defining STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl #(
    parameter int DIV        = 500000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_START_N,
    input  logic       KEY_LAP_N,
    input  logic       max_reached,
    output logic       tick,
    output logic       clr,
    output logic       hold,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    localparam int PW = $clog2(DIV);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    // Bit 0 is the start key, bit 1 the lap key.
    logic [1:0]    key_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    key_deb;
    logic [1:0]    press;
    logic [DW-1:0] deb_cnt [2];

    assign key_raw = {KEY_LAP_N, KEY_START_N};

    // NOTE: sequential state is written only with <=, so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            key_deb <= 2'b11;
            press   <= 2'b00;
            // NOTE: the counter array is plain flops rather than a RAM, so it is reset with everything else.
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != key_deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        key_deb[i] <= sync2[i];
                        deb_cnt[i] <= '0;
                        press[i]   <= ~sync2[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick_d, clr_d, hold_d;
    logic          running, terminal;
    logic          start_p, lap_p;

    assign start_p = press[0];
    assign lap_p   = press[1];

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch appears.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        tick_d   = 1'b0;
        clr_d    = 1'b0;
        running  = (state_q == RUN) || (state_q == LAP);
        terminal = running && (pre_q == PRE_LAST);

        if (running) pre_d = terminal ? '0 : pre_q + PW'(1);

        // Terminal count at 99.99 swallows the tick and parks the chain, overriding any key press.
        if (terminal && max_reached) begin
            state_d = PAUSE;
        end else begin
            tick_d = terminal;
            if (start_p) begin
                case (state_q)
                    IDLE, PAUSE: state_d = RUN;
                    default:     state_d = PAUSE;
                endcase
            end else if (lap_p) begin
                case (state_q)
`ifdef STOPWATCH_CTRL_LAP_EN
                    RUN:     state_d = LAP;
                    LAP:     state_d = RUN;
`endif
                    PAUSE: begin
                        state_d = IDLE;
                        pre_d   = '0;
                        clr_d   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

`ifdef STOPWATCH_CTRL_LAP_EN
        hold_d = (state_d == LAP);
`else
        hold_d = 1'b0;
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            pre_q   <= '0;
            tick    <= 1'b0;
            clr     <= 1'b1;
            hold    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tick    <= tick_d;
            clr     <= clr_d;
            hold    <= hold_d;
        end
    end

    assign state = state_q;

endmodule
